// File: rtl/bounce_generator.sv
// Deterministic pseudo-random bouncing switch source: each request drives out_signal
// to a new level through a burst of toggles, settles, then pulses out_done.
// Optional build macro BOUNCE_GEN_FIXED_GAP_EN makes every gap exactly MIN_GAP cycles.
module bounce_generator #(
  parameter int          NUM_BOUNCES  = 4,
  parameter int          MIN_GAP      = 2,
  parameter int          GAP_BITS     = 3,
  parameter int          SETTLE_TICKS = 64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_start,
  input  logic in_level,
  output logic out_signal,
  output logic out_busy,
  output logic out_done
);

  localparam int TOGGLES = 2 * NUM_BOUNCES + 1;
  localparam int GAP_W   = $clog2(MIN_GAP + 2 ** GAP_BITS) + 1;
  localparam int TOG_W   = $clog2(TOGGLES + 1);
  localparam int SET_W   = $clog2(SETTLE_TICKS) + 1;

  localparam logic [15:0]      LFSR_TAPS  = 16'hB400;
  localparam logic [TOG_W-1:0] TOGGLES_L  = TOG_W'(TOGGLES);
  localparam logic [SET_W-1:0] SETTLE_L   = SET_W'(SETTLE_TICKS);
  localparam logic [GAP_W-1:0] MIN_GAP_L  = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUNCE,
    S_GAP,
    S_SETTLE
  } state_e;

  state_e           state_q, state_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [SET_W-1:0] settle_q, settle_d;

  logic [TOG_W-1:0] tog_inc;
  logic [GAP_W-1:0] gap_len;

  // Galois step: shift right, fold the tap mask in when the bit shifted out is 1.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_comb begin
`ifdef BOUNCE_GEN_FIXED_GAP_EN
    gap_len = MIN_GAP_L;
`else
    gap_len = MIN_GAP_L + GAP_W'(lfsr_q[GAP_BITS-1:0]);
`endif
  end

  always_comb begin
    tog_inc  = tog_q + TOG_W'(1);
    state_d  = state_q;
    signal_d = signal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tog_d    = tog_q;
    gap_d    = gap_q;
    settle_d = settle_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          if (in_level != signal_q) begin
            state_d = S_BOUNCE;
            busy_d  = 1'b1;
            tog_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      // One toggle per visit; the odd toggle count guarantees the burst lands on the target.
      S_BOUNCE: begin
        signal_d = ~signal_q;
        tog_d    = tog_inc;
        if (tog_inc == TOGGLES_L) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_L;
        end else begin
          state_d = S_GAP;
          gap_d   = gap_len;
        end
      end

      S_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = S_BOUNCE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_SETTLE: begin
        if (settle_q <= SET_W'(1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          settle_d = '0;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= S_IDLE;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      tog_q    <= '0;
      gap_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lfsr_q   <= lfsr_d;
      tog_q    <= tog_d;
      gap_q    <= gap_d;
      settle_q <= settle_d;
    end
  end

  assign out_signal = signal_q;
  assign out_busy   = busy_q;
  assign out_done   = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: three instances (small fixed-style config,
// default config, single-toggle config) driven by a linear sequence of steps.
module tb_bounce_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  logic [2:0] level;
  logic [2:0] sig;
  logic [2:0] busy;
  logic [2:0] done;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] m_lfsr;
  int          obs_e[16];
  int          obs_n;
  int          save_e[16];
  int          save_n;

  always #5 clk = ~clk;

  bounce_generator #(.NUM_BOUNCES(2), .MIN_GAP(2), .GAP_BITS(3), .SETTLE_TICKS(8)) dut_a (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start[0]), .in_level(level[0]),
    .out_signal(sig[0]), .out_busy(busy[0]), .out_done(done[0])
  );

  bounce_generator dut_b (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start[1]), .in_level(level[1]),
    .out_signal(sig[1]), .out_busy(busy[1]), .out_done(done[1])
  );

  bounce_generator #(.NUM_BOUNCES(0), .MIN_GAP(2), .GAP_BITS(3), .SETTLE_TICKS(8)) dut_c (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start[2]), .in_level(level[2]),
    .out_signal(sig[2]), .out_busy(busy[2]), .out_done(done[2])
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR: all instances share seed, clock and reset, so one copy serves them all.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int gap_of(input logic [15:0] v, input int mg, input int gb);
    int mask;
    mask = (1 << gb) - 1;
`ifdef BOUNCE_GEN_FIXED_GAP_EN
    mask = 0;
`endif
    return mg + (int'(v) & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_sig%0d", i), 32'(sig[i]), 0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 0);
    end
    rst_n = 1'b1;
  endtask

  // Request a transition, then check every edge up to the done pulse against
  // toggle edges predicted from the reference LFSR.
  task automatic run(input string name, input int id, input logic lvl, input int nb,
                     input int mg, input int gb, input int st, input int glitch,
                     input int abort_at);
    int          ntog;
    int          dedge;
    int          cnt;
    int          exp_e[16];
    logic        s0;
    logic        prev;
    logic [15:0] v;
    ntog     = 2 * nb + 1;
    s0       = sig[id];
    exp_e[0] = 1;
    for (int i = 1; i < ntog; i++) begin
      v = m_lfsr;
      for (int j = 0; j < exp_e[i-1]; j++) v = lfsr_next(v);
      exp_e[i] = exp_e[i-1] + gap_of(v, mg, gb) + 1;
    end
    dedge = exp_e[ntog-1] + st;
    obs_n = 0;
    prev  = s0;

    start[id] = 1'b1;
    level[id] = lvl;
    @(negedge clk);
    start[id] = 1'b0;
    chk({name, "_acc_busy"}, 32'(busy[id]), 1);
    chk({name, "_acc_done"}, 32'(done[id]), 0);
    chk({name, "_acc_sig"}, 32'(sig[id]), 32'(s0));

    for (int e = 1; e <= dedge; e++) begin
      if (e == glitch) begin
        start[id] = 1'b1;
        level[id] = ~lvl;
      end
      @(negedge clk);
      start[id] = 1'b0;
      level[id] = lvl;
      cnt = 0;
      for (int i = 0; i < ntog; i++) if (exp_e[i] <= e) cnt++;
      if (sig[id] !== prev && obs_n < 16) begin
        obs_e[obs_n] = e;
        obs_n++;
      end
      prev = sig[id];
      chk($sformatf("%s_e%0d_sig", name, e), 32'(sig[id]), 32'(s0 ^ cnt[0]));
      chk($sformatf("%s_e%0d_busy", name, e), 32'(busy[id]), 32'(e < dedge));
      chk($sformatf("%s_e%0d_done", name, e), 32'(done[id]), 32'(e == dedge));
      if (e == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({name, "_abort_sig"}, 32'(sig[id]), 0);
        chk({name, "_abort_busy"}, 32'(busy[id]), 0);
        chk({name, "_abort_done"}, 32'(done[id]), 0);
        @(negedge clk);
        chk({name, "_abort_done2"}, 32'(done[id]), 0);
        chk({name, "_abort_sig2"}, 32'(sig[id]), 0);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic same_level(input string name, input int id, input logic lvl);
    start[id] = 1'b1;
    level[id] = lvl;
    @(negedge clk);
    start[id] = 1'b0;
    chk({name, "_busy"}, 32'(busy[id]), 0);
    chk({name, "_done"}, 32'(done[id]), 1);
    chk({name, "_sig"}, 32'(sig[id]), 32'(lvl));
    @(negedge clk);
    chk({name, "_done_clr"}, 32'(done[id]), 0);
    chk({name, "_busy2"}, 32'(busy[id]), 0);
    chk({name, "_sig2"}, 32'(sig[id]), 32'(lvl));
  endtask

  initial begin
    int fixed_e[5];
    int d;
    rst_n = 1'b0;
    start = '0;
    level = '0;
    fixed_e = '{1, 4, 7, 10, 13};
    repeat (2) @(negedge clk);

    // Test 1: rise to 1 through 5 toggles
    do_reset();
    run("t1", 0, 1'b1, 2, 2, 3, 8, 0, 0);
    chk("t1_ntog", 32'(obs_n), 5);
    chk("t1_final", 32'(sig[0]), 1);
`ifdef BOUNCE_GEN_FIXED_GAP_EN
    for (int i = 0; i < 5; i++) chk($sformatf("t1_edge%0d", i), 32'(obs_e[i]), 32'(fixed_e[i]));
`endif

    // Test 2: start towards the level already present
    do_reset();
    same_level("t2a", 0, 1'b0);
    same_level("t2b", 1, 1'b0);

    // Test 3: conflicting start while busy is ignored
    do_reset();
    run("t3", 0, 1'b1, 2, 2, 3, 8, 5, 0);
    chk("t3_ntog", 32'(obs_n), 5);
    chk("t3_final", 32'(sig[0]), 1);

    // Test 4: reset mid-burst, then a clean restart
    do_reset();
    run("t4", 0, 1'b1, 2, 2, 3, 8, 0, 7);
    run("t4r", 0, 1'b1, 2, 2, 3, 8, 0, 0);
    chk("t4r_first", 32'(obs_e[0]), 1);
    chk("t4r_ntog", 32'(obs_n), 5);

    // Test 5: default parameters, random gaps, repeatable from reset
    do_reset();
    run("t5", 1, 1'b1, 4, 2, 3, 64, 0, 0);
    chk("t5_ntog", 32'(obs_n), 9);
    chk("t5_final", 32'(sig[1]), 1);
    for (int i = 1; i < 9; i++) begin
      d = obs_e[i] - obs_e[i-1];
      chk($sformatf("t5_spacing%0d_in_3_10", i), 32'(d >= 3 && d <= 10), 1);
    end
    save_n = obs_n;
    for (int i = 0; i < 16; i++) save_e[i] = obs_e[i];
    do_reset();
    run("t5b", 1, 1'b1, 4, 2, 3, 64, 0, 0);
    chk("t5b_ntog", 32'(obs_n), 32'(save_n));
    for (int i = 0; i < 9; i++) chk($sformatf("t5b_same_edge%0d", i), 32'(obs_e[i]), 32'(save_e[i]));

    // Test 6: single clean toggle, back-to-back request on the done cycle
    do_reset();
    run("t6", 2, 1'b1, 0, 2, 3, 8, 0, 0);
    chk("t6_ntog", 32'(obs_n), 1);
    chk("t6_edge", 32'(obs_e[0]), 1);
    run("t6b", 2, 1'b0, 0, 2, 3, 8, 0, 0);
    chk("t6b_ntog", 32'(obs_n), 1);
    chk("t6b_final", 32'(sig[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
